// File: rtl/pulse_stat_window_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_stat_window_ctrl
//
// Sequences measurement windows for the pulse classification / statistics
// datapath while machining. Each window:
//   1. issues a one-cycle count-clear pulse (feedback_finished),
//   2. enables statistics counting for N cycles
//      (N = cfg_window, or WINDOW_CYCLES when cfg_window == 0),
//   3. waits DIV_LATENCY cycles for the rate dividers to settle,
//   4. captures the four 8-bit pulse rates and offers them to the gap servo
//      over a valid/ready handshake.
// While is_machine stays high the window repeats with a period of
// N + DIV_LATENCY + 2 cycles. Dropping is_machine during counting aborts the
// window (one clear pulse, then idle). Dropping it while settling lets the
// window complete.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous reset, active-high
//   is_machine          machining enabled
//   cfg_window[23:0]    window length in cycles, sampled in CLEAR; 0 = default
//   *_rate_in[7:0]      normal / arc / open / short rates from the statistics
//                       block (0..100, 8'hFF = invalid / overflow)
//   stat_count_en       high while statistics counting is permitted
//   feedback_finished   one-cycle clear pulse to statistics counters/dividers
//   rate_valid          captured rate set available
//   rate_ready          consumer accepts the set
//   *_rate[7:0]         captured rates, stable while rate_valid is high
//   rate_error          any captured rate == 8'hFF (qualified by rate_valid)
//   overrun             sticky: a capture overwrote an unaccepted set
//   window_seq          number of completed captures, wraps modulo 2^SEQ_W
//
// Parameters:
//   WINDOW_CYCLES  default window length (truncated to 24 bits)
//   DIV_LATENCY    counting-stop to rates-valid latency, 1..255
//   SEQ_W          width of window_seq
// -----------------------------------------------------------------------------
module pulse_stat_window_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned DIV_LATENCY   = 34,
  parameter int unsigned SEQ_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_machine,
  input  logic [23:0]      cfg_window,
  input  logic [7:0]       normal_rate_in,
  input  logic [7:0]       arc_rate_in,
  input  logic [7:0]       open_rate_in,
  input  logic [7:0]       short_rate_in,
  output logic             stat_count_en,
  output logic             feedback_finished,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [7:0]       normal_rate,
  output logic [7:0]       arc_rate,
  output logic [7:0]       open_rate,
  output logic [7:0]       short_rate,
  output logic             rate_error,
  output logic             overrun,
  output logic [SEQ_W-1:0] window_seq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  // The window counter is 24 bits wide; an oversized default is truncated.
  localparam logic [23:0] WIN_DEFAULT = WINDOW_CYCLES[23:0];
  localparam logic [7:0]  SET_LOAD    = DIV_LATENCY[7:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [23:0]      win_cnt_q,     win_cnt_d;
  logic [7:0]       set_cnt_q,     set_cnt_d;
  // Marks a CLEAR that belongs to an aborted window: it returns to IDLE
  // instead of starting a new RUN.
  logic             abort_q,       abort_d;

  logic             rate_valid_q,  rate_valid_d;
  logic [7:0]       normal_q,      normal_d;
  logic [7:0]       arc_q,         arc_d;
  logic [7:0]       open_q,        open_d;
  logic [7:0]       short_q,       short_d;
  logic             rate_error_q,  rate_error_d;
  logic             overrun_q,     overrun_d;
  logic [SEQ_W-1:0] window_seq_q,  window_seq_d;

  logic             capture;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  // NOTE: every flop here uses non-blocking assignment so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      win_cnt_q    <= '0;
      set_cnt_q    <= '0;
      abort_q      <= 1'b0;
      rate_valid_q <= 1'b0;
      normal_q     <= '0;
      arc_q        <= '0;
      open_q       <= '0;
      short_q      <= '0;
      rate_error_q <= 1'b0;
      overrun_q    <= 1'b0;
      window_seq_q <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      set_cnt_q    <= set_cnt_d;
      abort_q      <= abort_d;
      rate_valid_q <= rate_valid_d;
      normal_q     <= normal_d;
      arc_q        <= arc_d;
      open_q       <= open_d;
      short_q      <= short_d;
      rate_error_q <= rate_error_d;
      overrun_q    <= overrun_d;
      window_seq_q <= window_seq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Window sequencer: next state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    win_cnt_d         = win_cnt_q;
    set_cnt_d         = set_cnt_q;
    abort_d           = abort_q;
    stat_count_en     = 1'b0;
    feedback_finished = 1'b0;
    capture           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_machine) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        feedback_finished = 1'b1;
        if (abort_q) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          win_cnt_d = (cfg_window == 24'd0) ? WIN_DEFAULT : cfg_window;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        stat_count_en = 1'b1;
        win_cnt_d     = win_cnt_q - 24'd1;
        // Losing is_machine wins over the last counting cycle: the partial
        // window is discarded and the counters are cleared once more.
        if (!is_machine) begin
          abort_d = 1'b1;
          state_d = S_CLEAR;
        end else if (win_cnt_q == 24'd1) begin
          set_cnt_d = SET_LOAD;
          state_d   = S_SETTLE;
        end
      end

      S_SETTLE: begin
        set_cnt_d = set_cnt_q - 8'd1;
        if (set_cnt_q == 8'd1) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        capture = 1'b1;
        state_d = is_machine ? S_CLEAR : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture register and valid/ready handshake
  // ---------------------------------------------------------------------------
  assign accept = rate_valid_q & rate_ready;

  always_comb begin
    rate_valid_d = rate_valid_q;
    normal_d     = normal_q;
    arc_d        = arc_q;
    open_d       = open_q;
    short_d      = short_q;
    rate_error_d = rate_error_q;
    overrun_d    = overrun_q;
    window_seq_d = window_seq_q;

    if (capture) begin
      normal_d     = normal_rate_in;
      arc_d        = arc_rate_in;
      open_d       = open_rate_in;
      short_d      = short_rate_in;
      rate_error_d = (normal_rate_in == 8'hFF) | (arc_rate_in == 8'hFF) |
                     (open_rate_in == 8'hFF) | (short_rate_in == 8'hFF);
      window_seq_d = window_seq_q + SEQ_W'(1);
      // A set accepted in this same cycle is consumed, not lost.
      rate_valid_d = 1'b1;
      if (rate_valid_q && !rate_ready) begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rate_valid_d = 1'b0;
    end
  end

  assign rate_valid  = rate_valid_q;
  assign normal_rate = normal_q;
  assign arc_rate    = arc_q;
  assign open_rate   = open_q;
  assign short_rate  = short_q;
  assign rate_error  = rate_error_q;
  assign overrun     = overrun_q;
  assign window_seq  = window_seq_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  // The clear pulse is never longer than one cycle.
  a_ff_single: assert property (@(posedge clk) disable iff (rst)
    feedback_finished |=> !feedback_finished);

  // Counting and clearing never overlap.
  a_en_ff_excl: assert property (@(posedge clk) disable iff (rst)
    !(feedback_finished && stat_count_en));

  // overrun is sticky until reset.
  a_overrun_sticky: assert property (@(posedge clk) disable iff (rst)
    overrun |=> overrun);

endmodule

// File: tb/tb_pulse_stat_window_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pulse_stat_window_ctrl (WINDOW_CYCLES=16, DIV_LATENCY=4).
// A reference model tracks the position inside the current window as a plain
// integer (-1 idle, 0 clear, 1..len counting, then settling, then capture)
// and the handshake/capture registers as ordinary variables. Every cycle the
// DUT outputs are compared with the model; scenario tasks add absolute
// checks taken directly from the timing rules.
// -----------------------------------------------------------------------------
module tb_pulse_stat_window_ctrl;

  localparam int WIN   = 16;
  localparam int LAT   = 4;
  localparam int SEQ_W = 8;
  localparam int VW    = 45;

  logic             clk = 1'b0;
  logic             rst;
  logic             is_machine;
  logic [23:0]      cfg_window;
  logic [7:0]       normal_rate_in, arc_rate_in, open_rate_in, short_rate_in;
  logic             stat_count_en, feedback_finished, rate_valid, rate_ready;
  logic [7:0]       normal_rate, arc_rate, open_rate, short_rate;
  logic             rate_error, overrun;
  logic [SEQ_W-1:0] window_seq;

  pulse_stat_window_ctrl #(
    .WINDOW_CYCLES(WIN),
    .DIV_LATENCY  (LAT),
    .SEQ_W        (SEQ_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .is_machine       (is_machine),
    .cfg_window       (cfg_window),
    .normal_rate_in   (normal_rate_in),
    .arc_rate_in      (arc_rate_in),
    .open_rate_in     (open_rate_in),
    .short_rate_in    (short_rate_in),
    .stat_count_en    (stat_count_en),
    .feedback_finished(feedback_finished),
    .rate_valid       (rate_valid),
    .rate_ready       (rate_ready),
    .normal_rate      (normal_rate),
    .arc_rate         (arc_rate),
    .open_rate        (open_rate),
    .short_rate       (short_rate),
    .rate_error       (rate_error),
    .overrun          (overrun),
    .window_seq       (window_seq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_pos   = -1;   // -1 idle, 0 clear, 1..m_len count, then settle, then capture
  int         m_len   = 0;
  bit         m_abort = 1'b0; // current cycle is the clear pulse of an aborted window
  bit         m_valid = 1'b0;
  bit         m_err   = 1'b0;
  bit         m_ovr   = 1'b0;
  logic [7:0] m_rate [4] = '{default: 8'h00};
  int         m_seq   = 0;

  task automatic model_step();
    bit cap;
    bit acc;
    if (rst) begin
      m_pos = -1; m_len = 0; m_abort = 0;
      m_valid = 0; m_err = 0; m_ovr = 0; m_seq = 0;
      m_rate = '{default: 8'h00};
      return;
    end
    cap = !m_abort && (m_pos == m_len + LAT + 1);
    acc = m_valid && rate_ready;
    if (cap) begin
      if (m_valid && !rate_ready) m_ovr = 1;
      m_rate[0] = normal_rate_in;
      m_rate[1] = arc_rate_in;
      m_rate[2] = open_rate_in;
      m_rate[3] = short_rate_in;
      m_err = (normal_rate_in == 8'hFF) || (arc_rate_in == 8'hFF) ||
              (open_rate_in == 8'hFF) || (short_rate_in == 8'hFF);
      m_seq = (m_seq + 1) % (1 << SEQ_W);
      m_valid = 1;
    end else if (acc) begin
      m_valid = 0;
    end
    if (m_abort) begin
      m_abort = 0;
      m_pos = -1;
    end else if (m_pos == -1) begin
      if (is_machine) m_pos = 0;
    end else if (m_pos == 0) begin
      m_len = (cfg_window == 24'd0) ? WIN : int'(cfg_window);
      m_pos = 1;
    end else if (m_pos <= m_len) begin
      if (!is_machine) begin
        m_abort = 1;
        m_pos = -1;
      end else begin
        m_pos++;
      end
    end else if (m_pos <= m_len + LAT) begin
      m_pos++;
    end else begin
      m_pos = is_machine ? 0 : -1;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic ff, en;
    ff = (m_pos == 0) || m_abort;
    en = (m_pos >= 1) && (m_pos <= m_len);
    return {en, ff, m_valid, m_err, m_ovr,
            m_rate[0], m_rate[1], m_rate[2], m_rate[3], SEQ_W'(m_seq)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {stat_count_en, feedback_finished, rate_valid, rate_error, overrun,
            normal_rate, arc_rate, open_rate, short_rate, window_seq};
  endfunction

  // Advance one clock; the model consumes the same inputs the DUT samples.
  // Returns at the falling edge, where outputs are compared and inputs change.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_rates(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    normal_rate_in = a;
    arc_rate_in    = b;
    open_rate_in   = c;
    short_rate_in  = d;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; is_machine = 0; rate_ready = 0; cfg_window = '0;
    set_rates(8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    n_vec++;
    if (dut_vec() !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    rst = 0;
    tick();
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  // is_machine rises at t=0: clear at t=1, counting t=2..17, data at t=23.
  task automatic test_timing();
    logic [2:0] obs, req;
    set_rates(8'd60, 8'd20, 8'd15, 8'd5);
    rate_ready = 1; cfg_window = '0; is_machine = 1;
    for (int t = 1; t <= 67; t++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL timing_model t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
      end
      if (t <= 23) begin
        obs = {feedback_finished, stat_count_en, rate_valid};
        req = {(t == 1 || t == 23), (t >= 2 && t <= 17), (t == 23)};
        n_vec++;
        if (obs !== req) begin
          n_err++; $display("FAIL timing_abs t=%0d ff/en/valid got=%b exp=%b", t, obs, req);
        end
      end
      if (t == 23) begin
        n_vec++;
        if ({normal_rate, arc_rate, open_rate, short_rate, rate_error} !==
            {8'd60, 8'd20, 8'd15, 8'd5, 1'b0}) begin
          n_err++; $display("FAIL timing_data got=%0d/%0d/%0d/%0d err=%b exp=60/20/15/5 err=0",
                            normal_rate, arc_rate, open_rate, short_rate, rate_error);
        end
      end
    end
    n_vec++;
    if ({window_seq, overrun} !== {8'd3, 1'b0}) begin
      n_err++; $display("FAIL timing_seq seq=%0d ovr=%b exp seq=3 ovr=0", window_seq, overrun);
    end
  endtask

  task automatic test_cfg_window();
    bit seen;
    int cnt;
    cfg_window = 24'd8;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL cfg_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (feedback_finished) seen = 1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL cfg_wait_clear timeout got=0 exp=1"); end
    // Window loaded with 8; a mid-window change to 3 applies to the next one.
    for (int w = 0; w < 2; w++) begin
      cnt = 0; seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        tick();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL cfg_model got=%h exp=%h", dut_vec(), exp_vec());
        end
        if (feedback_finished) seen = 1;
        else if (stat_count_en) cnt++;
        if (w == 0 && i == 2) cfg_window = 24'd3;
      end
      n_vec++;
      if (!seen || cnt != (w == 0 ? 8 : 3)) begin
        n_err++; $display("FAIL cfg_len window=%0d got=%0d exp=%0d", w, cnt, (w == 0 ? 8 : 3));
      end
    end
    cfg_window = '0;
  endtask

  task automatic test_overrun();
    logic [7:0] r [4];
    for (int k = 0; k < 4; k++) r[k] = 8'($urandom_range(0, 100));
    set_rates(r[0], r[1], r[2], r[3]);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_pre got=%b exp=0", overrun);
    end
    rate_ready = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ovr_model got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({overrun, rate_valid, normal_rate, arc_rate, open_rate, short_rate} !==
        {1'b1, 1'b1, r[0], r[1], r[2], r[3]}) begin
      n_err++; $display("FAIL ovr_set ovr=%b valid=%b data=%h exp ovr=1 valid=1 data=%h",
                        overrun, rate_valid, {normal_rate, arc_rate, open_rate, short_rate},
                        {r[0], r[1], r[2], r[3]});
    end
    rate_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky got=%b exp=1", overrun);
    end
  endtask

  task automatic wait_valid(input bit level, input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL %s_model got=%h exp=%h", tag, dut_vec(), exp_vec());
      end
      if (rate_valid === level) seen = 1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL %s_wait timeout valid got=%b exp=%b", tag, rate_valid, level); end
  endtask

  task automatic test_rate_error();
    rate_ready = 1; is_machine = 1;
    wait_valid(1'b0, "err");
    set_rates(8'd40, 8'd30, 8'd20, 8'hFF);
    wait_valid(1'b1, "err");
    n_vec++;
    if ({rate_error, short_rate} !== {1'b1, 8'hFF}) begin
      n_err++; $display("FAIL err_set err=%b short=%h exp err=1 short=ff", rate_error, short_rate);
    end
    wait_valid(1'b0, "err");
    set_rates(8'd40, 8'd30, 8'd20, 8'd50);
    wait_valid(1'b1, "err");
    n_vec++;
    if ({rate_error, short_rate} !== {1'b0, 8'd50}) begin
      n_err++; $display("FAIL err_clr err=%b short=%0d exp err=0 short=50", rate_error, short_rate);
    end
  endtask

  task automatic test_abort();
    bit seen = 0;
    int ff_cnt = 0, en_cnt = 0, v_cnt = 0;
    logic [SEQ_W-1:0] seq0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (feedback_finished) seen = 1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL abort_wait_clear timeout got=0 exp=1"); end
    seq0 = SEQ_W'(m_seq);
    for (int i = 0; i < 5; i++) tick();   // now in counting cycle 5
    n_vec++;
    if (stat_count_en !== 1'b1) begin
      n_err++; $display("FAIL abort_run5 en got=%b exp=1", stat_count_en);
    end
    is_machine = 0;
    tick();
    n_vec++;
    if ({feedback_finished, stat_count_en} !== 2'b10) begin
      n_err++; $display("FAIL abort_clear ff/en got=%b exp=10", {feedback_finished, stat_count_en});
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL abort_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      ff_cnt += int'(feedback_finished);
      en_cnt += int'(stat_count_en);
      v_cnt  += int'(rate_valid);
    end
    n_vec++;
    if (ff_cnt != 0 || en_cnt != 0 || v_cnt != 0 || window_seq !== seq0) begin
      n_err++; $display("FAIL abort_idle ff=%0d en=%0d valid=%0d seq=%0d exp 0/0/0 seq=%0d",
                        ff_cnt, en_cnt, v_cnt, window_seq, seq0);
    end
  endtask

  task automatic test_reset_settle();
    bit seen = 0;
    is_machine = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (feedback_finished) seen = 1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL rst_wait_clear timeout got=0 exp=1"); end
    for (int i = 0; i < WIN + 2; i++) tick();   // second settling cycle
    n_vec++;
    if ({stat_count_en, feedback_finished} !== 2'b00) begin
      n_err++; $display("FAIL rst_settle en/ff got=%b exp=00", {stat_count_en, feedback_finished});
    end
    rst = 1;
    tick();
    n_vec++;
    if (dut_vec() !== '0) begin
      n_err++; $display("FAIL rst_in_settle got=%h exp=0", dut_vec());
    end
    rst = 0;
    tick();
    n_vec++;
    if ({feedback_finished, stat_count_en, rate_valid} !== 3'b100 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL rst_restart got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  // Capture while the previous set is accepted in the same cycle.
  task automatic test_back_to_back();
    bit hit = 0;
    rst = 1; tick(); rst = 0;
    rate_ready = 0; is_machine = 1; cfg_window = 24'd2;
    set_rates(8'd11, 8'd22, 8'd33, 8'd44);
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL b2b_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (m_valid && m_pos == m_len + LAT + 1) hit = 1;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL b2b_wait timeout got=0 exp=1"); end
    rate_ready = 1;
    set_rates(8'd55, 8'd66, 8'd77, 8'd88);
    tick();
    n_vec++;
    if ({rate_valid, overrun, normal_rate, arc_rate, open_rate, short_rate, window_seq} !==
        {1'b1, 1'b0, 8'd55, 8'd66, 8'd77, 8'd88, 8'd2}) begin
      n_err++; $display("FAIL b2b_capture valid=%b ovr=%b data=%h seq=%0d exp valid=1 ovr=0 data=37424d58 seq=2",
                        rate_valid, overrun, {normal_rate, arc_rate, open_rate, short_rate}, window_seq);
    end
    cfg_window = '0;
  endtask

  // Shortest window (7-cycle period): 257 captures wrap window_seq to 1.
  task automatic test_seq_wrap();
    rst = 1; tick(); rst = 0;
    rate_ready = 1; is_machine = 1; cfg_window = 24'd1;
    for (int t = 1; t <= 1 + 7 * 257; t++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL wrap_model t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (window_seq !== 8'd1) begin
      n_err++; $display("FAIL wrap_seq got=%0d exp=1", window_seq);
    end
    cfg_window = '0;
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      is_machine = ($urandom_range(0, 99) < 96);
      rate_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) cfg_window = 24'($urandom_range(0, 6));
      r = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 100));
      set_rates(8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)),
                8'($urandom_range(0, 100)), r);
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_cfg_window();
    test_overrun();
    test_rate_error();
    test_abort();
    test_reset_settle();
    test_back_to_back();
    test_seq_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
